oled_spi_sink: RTL and testbench
================================

# oled_spi_sink

Receiving end of the SSD1331 4-wire SPI link: oversamples `oled_csn`/`oled_clk`/`oled_mosi`/`oled_dc`/`oled_resn` in the system clock domain and deserializes bytes MSB first. Parses the column/row window commands, and turns data bytes into addressed 8-bit pixel writes. It is used as a display model in simulation and as an on-chip loopback checker, placed directly on the wires driven by the OLED video streamer.

## Interface
- `C_x_bits`, 7: width of column address and counters.
- `C_y_bits`, 6: width of row address and counters.
- `C_sync_stages`, 2: synchronizer flops on each SPI input (≥2).

Ports:
- `clk` in 1: system clock; must be ≥4× the `oled_clk` toggle rate.
- `resn` in 1: reset, asynchronous, active-low.
- `oled_csn` in 1: chip select, active-low.
- `oled_clk` in 1: SPI clock; data sampled on rising edge.
- `oled_mosi` in 1: serial data, MSB first.
- `oled_dc` in 1: 0 = command/argument byte, 1 = pixel data byte.
- `oled_resn` in 1: display reset, active-low, synchronized.
- `pixel_valid` out 1: one-cycle strobe per pixel byte.
- `pixel_x` out `C_x_bits`: column of strobed pixel.
- `pixel_y` out `C_y_bits`: row of strobed pixel.
- `pixel_color` out 8: RGB332 byte.
- `cmd_valid` out 1: one-cycle strobe per command byte not consumed as an argument.
- `cmd_byte` out 8: that command.
- `frame_done` out 1: one-cycle strobe on last pixel of window (see Configuration).

## Operation
- Each input is passed through `C_sync_stages` flops. A rising edge is detected when the synced `oled_clk` is 1 and its previous value was 0.
- Bit capture happens only while synced csn is 0:
  - On each rising edge, shift mosi into the shift register and increment the 3-bit counter.
  - dc is sampled together with bit 7 (the last bit).
- Synced csn at 1 clears the bit counter and discards a partial byte. Parser state and window state are kept.
- A byte completes when the 8th bit is captured.
  - dc=1: pixel write at current (x,y), then advance.
  - dc=0: the byte goes to the parser.
- Parser states: IDLE, COL_S, COL_E, ROW_S, ROW_E.
  - IDLE + 0x15 → COL_S. IDLE + 0x75 → ROW_S. Neither produces `cmd_valid`.
  - IDLE + any other byte → `cmd_valid`, stay in IDLE.
  - COL_S stores col_start → COL_E. COL_E stores col_end, sets x←col_start → IDLE.
  - ROW_S stores row_start → ROW_E. ROW_E stores row_end, sets y←row_start → IDLE.
  - Arguments are truncated to `C_x_bits`/`C_y_bits`.
  - A dc=1 byte in any argument state is still treated as a pixel; the parser state is unchanged.
- Pixel advance:
  - x==col_end → x←col_start, y advances. Otherwise x←x+1.
  - y advances to row_start if y==row_end, else y+1.
  - If start>end, the counter increments modulo 2^bits until it equals end.
- Synced `oled_resn`=0 acts as a synchronous clear while held:
  - Parser → IDLE; bit counter 0.
  - Window → defaults; x,y ← 0.
  - No strobes are issued.

## Timing
- Reset values:
  - All strobes 0; `pixel_x`/`pixel_y`/`pixel_color`/`cmd_byte` 0.
  - col_start 0, col_end 95, row_start 0, row_end 63; x,y 0; parser IDLE.
- Edge detect latency: `C_sync_stages`+1 clk from the `oled_clk` transition.
- Strobes: asserted on the clk cycle after the 8th edge is detected, high for exactly 1 cycle. Output data is valid with the strobe and held until the next strobe.
- Pixel coordinates are pre-advance values. Advance takes effect in the same cycle as the strobe.
- Edge detection with csn rising in the same synced cycle: csn wins and the bit is dropped.
- `resn` deassertion takes effect on the next clk edge.

## Configuration
- `OLED_SINK_FRAME_EN` defined: `frame_done` strobes in the same cycle as the `pixel_valid` whose pre-advance coordinates equal (col_end,row_end).
- Undefined: `frame_done` is tied to 0 and the comparison logic is omitted.

## Test plan
- Reset and default stream:
  - Stimulus: reset; send 96×64 dc=1 bytes, color = x^y.
  - Required: 6144 `pixel_valid` strobes, raster order (0,0)…(95,63), colors match.
  - Required: with the macro, `frame_done` fires once, at (95,63).
- Window commands:
  - Stimulus: 0x15,0x10,0x13 and 0x75,0x05,0x06 (dc=0), then 10 pixels.
  - Required: coordinates (16,5)…(19,5),(16,6)…(19,6),(16,5),(17,5). No `cmd_valid` for these 6 bytes.
- Plain command:
  - Stimulus: 0xAF (dc=0).
  - Required: `cmd_valid`=1 for one cycle, `cmd_byte`=0xAF, no pixel strobe.
- Aborted byte:
  - Stimulus: 5 bits, then csn high, then a full pixel byte 0x3C.
  - Required: single strobe, color 0x3C, at (0,0).
- Display reset mid-window:
  - Stimulus: set window 0x15,0x20,0x21; pulse `oled_resn` low; send 1 pixel.
  - Required: pixel at (0,0); the next 96 pixels wrap to row 1.
- Mid-argument dc=1:
  - Stimulus: 0x15, then pixel 0x55, then 0x02,0x03.
  - Required: pixel at the old (x,y); window becomes 2..3.

Source files
------------

// File: rtl/oled_spi_sink.sv
// oled_spi_sink: receiving end of an SSD1331 4-wire SPI link.
// All SPI wires are oversampled in the clk domain. Bytes are shifted in MSB first.
// Command bytes go to a small window-command parser.
// Pixel bytes become addressed writes that walk the current column/row window.
// Optional feature macro OLED_SINK_FRAME_EN: when defined, frame_done strobes with
// the pixel written at (col_end,row_end). Otherwise frame_done is tied low.
//
// state    | meaning
// ST_IDLE  | waiting for a command byte
// ST_COL_S | next command byte is the column start
// ST_COL_E | next command byte is the column end
// ST_ROW_S | next command byte is the row start
// ST_ROW_E | next command byte is the row end
module oled_spi_sink #(
  parameter int C_x_bits      = 7,
  parameter int C_y_bits      = 6,
  parameter int C_sync_stages = 2
) (
  input  logic                clk,
  input  logic                resn,
  input  logic                oled_csn,
  input  logic                oled_clk,
  input  logic                oled_mosi,
  input  logic                oled_dc,
  input  logic                oled_resn,
  output logic                pixel_valid,
  output logic [C_x_bits-1:0] pixel_x,
  output logic [C_y_bits-1:0] pixel_y,
  output logic [7:0]          pixel_color,
  output logic                cmd_valid,
  output logic [7:0]          cmd_byte,
  output logic                frame_done
);

  typedef enum logic [2:0] {ST_IDLE, ST_COL_S, ST_COL_E, ST_ROW_S, ST_ROW_E} state_t;

  localparam logic [C_x_bits-1:0] XMAX_DEF = C_x_bits'(95);
  localparam logic [C_y_bits-1:0] YMAX_DEF = C_y_bits'(63);

  // bit order in each sync stage: {resn, dc, mosi, clk, csn}
  logic [C_sync_stages-1:0][4:0] sync_q;
  logic csn_s, sclk_s, mosi_s, dc_s, resn_s, sclk_prev_q, rise;

  state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] byte_w;
  logic [C_x_bits-1:0] col_start_q, col_start_d, col_end_q, col_end_d, x_q, x_d;
  logic [C_y_bits-1:0] row_start_q, row_start_d, row_end_q, row_end_d, y_q, y_d;
  logic                pixel_valid_q, pixel_valid_d, cmd_valid_q, cmd_valid_d;
  logic [C_x_bits-1:0] pixel_x_q, pixel_x_d;
  logic [C_y_bits-1:0] pixel_y_q, pixel_y_d;
  logic [7:0]          pixel_color_q, pixel_color_d, cmd_byte_q, cmd_byte_d;
`ifdef OLED_SINK_FRAME_EN
  logic frame_done_q, frame_done_d;
`endif

  assign csn_s  = sync_q[C_sync_stages-1][0];
  assign sclk_s = sync_q[C_sync_stages-1][1];
  assign mosi_s = sync_q[C_sync_stages-1][2];
  assign dc_s   = sync_q[C_sync_stages-1][3];
  assign resn_s = sync_q[C_sync_stages-1][4];
  assign rise   = sclk_s & ~sclk_prev_q;
  assign byte_w = {shift_q, mosi_s};

  // Byte capture, command parsing and pixel address walk.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    col_start_d   = col_start_q;
    col_end_d     = col_end_q;
    row_start_d   = row_start_q;
    row_end_d     = row_end_q;
    x_d           = x_q;
    y_d           = y_q;
    pixel_valid_d = 1'b0;
    cmd_valid_d   = 1'b0;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    pixel_color_d = pixel_color_q;
    cmd_byte_d    = cmd_byte_q;
`ifdef OLED_SINK_FRAME_EN
    frame_done_d  = 1'b0;
`endif
    if (!resn_s) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = 3'd0;
      col_start_d = '0;
      col_end_d   = XMAX_DEF;
      row_start_d = '0;
      row_end_d   = YMAX_DEF;
      x_d         = '0;
      y_d         = '0;
    end else if (csn_s) begin
      // deselect drops any partial byte; parser and window survive
      bit_cnt_d = 3'd0;
    end else if (rise) begin
      shift_d   = {shift_q[5:0], mosi_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        if (dc_s) begin
          pixel_valid_d = 1'b1;
          pixel_x_d     = x_q;
          pixel_y_d     = y_q;
          pixel_color_d = byte_w;
`ifdef OLED_SINK_FRAME_EN
          frame_done_d  = (x_q == col_end_q) && (y_q == row_end_q);
`endif
          if (x_q == col_end_q) begin
            x_d = col_start_q;
            y_d = (y_q == row_end_q) ? row_start_q : y_q + C_y_bits'(1);
          end else begin
            x_d = x_q + C_x_bits'(1);
          end
        end else begin
          unique case (state_q)
            ST_IDLE: begin
              if (byte_w == 8'h15)      state_d = ST_COL_S;
              else if (byte_w == 8'h75) state_d = ST_ROW_S;
              else begin
                cmd_valid_d = 1'b1;
                cmd_byte_d  = byte_w;
              end
            end
            ST_COL_S: begin
              col_start_d = byte_w[C_x_bits-1:0];
              state_d     = ST_COL_E;
            end
            ST_COL_E: begin
              col_end_d = byte_w[C_x_bits-1:0];
              x_d       = col_start_q;
              state_d   = ST_IDLE;
            end
            ST_ROW_S: begin
              row_start_d = byte_w[C_y_bits-1:0];
              state_d     = ST_ROW_E;
            end
            ST_ROW_E: begin
              row_end_d = byte_w[C_y_bits-1:0];
              y_d       = row_start_q;
              state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
    end
  end

  // Synchronizers and all state registers.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      sync_q        <= {C_sync_stages{5'b00001}};
      sclk_prev_q   <= 1'b0;
      state_q       <= ST_IDLE;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 7'd0;
      col_start_q   <= '0;
      col_end_q     <= XMAX_DEF;
      row_start_q   <= '0;
      row_end_q     <= YMAX_DEF;
      x_q           <= '0;
      y_q           <= '0;
      pixel_valid_q <= 1'b0;
      cmd_valid_q   <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      pixel_color_q <= 8'd0;
      cmd_byte_q    <= 8'd0;
`ifdef OLED_SINK_FRAME_EN
      frame_done_q  <= 1'b0;
`endif
    end else begin
      sync_q        <= {sync_q[C_sync_stages-2:0], {oled_resn, oled_dc, oled_mosi, oled_clk, oled_csn}};
      sclk_prev_q   <= sclk_s;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      col_start_q   <= col_start_d;
      col_end_q     <= col_end_d;
      row_start_q   <= row_start_d;
      row_end_q     <= row_end_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pixel_valid_q <= pixel_valid_d;
      cmd_valid_q   <= cmd_valid_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      pixel_color_q <= pixel_color_d;
      cmd_byte_q    <= cmd_byte_d;
`ifdef OLED_SINK_FRAME_EN
      frame_done_q  <= frame_done_d;
`endif
    end
  end

  assign pixel_valid = pixel_valid_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign pixel_color = pixel_color_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_byte    = cmd_byte_q;
`ifdef OLED_SINK_FRAME_EN
  assign frame_done  = frame_done_q;
`else
  assign frame_done  = 1'b0;
`endif

endmodule

// File: tb/tb_oled_spi_sink.sv
// Bench for oled_spi_sink: drives SPI bytes, predicts strobes with a byte-level
// model of the display window, and compares every strobe against the prediction.
module tb_oled_spi_sink;

  logic clk = 1'b0, resn = 1'b0;
  logic oled_csn = 1'b1, oled_clk = 1'b0, oled_mosi = 1'b0, oled_dc = 1'b0, oled_resn = 1'b1;
  logic       pixel_valid, cmd_valid, frame_done;
  logic [6:0] pixel_x;
  logic [5:0] pixel_y;
  logic [7:0] pixel_color, cmd_byte;

  oled_spi_sink #(.C_x_bits(7), .C_y_bits(6), .C_sync_stages(2)) dut (
    .clk(clk), .resn(resn), .oled_csn(oled_csn), .oled_clk(oled_clk),
    .oled_mosi(oled_mosi), .oled_dc(oled_dc), .oled_resn(oled_resn),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_color(pixel_color), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_pix;
    int x;
    int y;
    int val;
    bit frame;
  } ev_t;

  ev_t expq[$];
  int  checks = 0, errors = 0;
  int  mx, my, mcs, mce, mrs, mre, mps;
  int  n_pix = 0, n_cmd = 0, n_frame = 0, last_x = 0, last_y = 0, last_col = 0, last_cmd = 0;
  bit  mon_en = 1'b0;
  int  base_cmd, base_pix, exp_frames;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic m_reset();
    mps = 0; mcs = 0; mce = 95; mrs = 0; mre = 63; mx = 0; my = 0;
  endtask

  // Display model: 0=idle, 1=col start, 2=col end, 3=row start, 4=row end.
  task automatic m_byte(input int b, input bit dc);
    ev_t e;
    if (dc) begin
      e.is_pix = 1'b1; e.x = mx; e.y = my; e.val = b;
`ifdef OLED_SINK_FRAME_EN
      e.frame = (mx == mce) && (my == mre);
`else
      e.frame = 1'b0;
`endif
      expq.push_back(e);
      if (mx == mce) begin
        mx = mcs;
        my = (my == mre) ? mrs : (my + 1) % 64;
      end else begin
        mx = (mx + 1) % 128;
      end
    end else begin
      case (mps)
        0: if (b == 'h15) mps = 1;
           else if (b == 'h75) mps = 3;
           else begin
             e.is_pix = 1'b0; e.x = 0; e.y = 0; e.val = b; e.frame = 1'b0;
             expq.push_back(e);
           end
        1: begin mcs = b % 128; mps = 2; end
        2: begin mce = b % 128; mx = mcs; mps = 0; end
        3: begin mrs = b % 64; mps = 4; end
        default: begin mre = b % 64; my = mrs; mps = 0; end
      endcase
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input logic dc);
    @(negedge clk);
    for (int i = 7; i > 7 - n; i--) begin
      oled_mosi = b[i];
      oled_dc   = dc;
      oled_clk  = 1'b0;
      repeat (2) @(negedge clk);
      oled_clk = 1'b1;
      repeat (2) @(negedge clk);
    end
    oled_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    m_byte(int'(b), dc);
    send_bits(b, 8, dc);
  endtask

  task automatic pix_xy();
    send_byte(8'(mx ^ my), 1'b1);
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  task automatic abort_bits(input int n);
    send_bits(8'($urandom), n, 1'($urandom));
    oled_csn = 1'b1;
    repeat (6) @(negedge clk);
    oled_csn = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic resn_pulse();
    settle();
    oled_resn = 1'b0;
    m_reset();
    repeat (8) @(negedge clk);
    oled_resn = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Compare every strobe cycle against the model's next predicted event.
  always @(negedge clk) begin
    if (mon_en) begin
      ev_t e;
      check("frame_without_pixel", {31'd0, frame_done & ~pixel_valid}, 32'd0);
      if (pixel_valid || cmd_valid) begin
        check("dual_strobe", {31'd0, pixel_valid & cmd_valid}, 32'd0);
        if (expq.size() == 0) begin
          check("unexpected_strobe", {31'd0, pixel_valid | cmd_valid}, 32'd0);
        end else begin
          e = expq.pop_front();
          check("strobe_kind", {31'd0, pixel_valid}, {31'd0, e.is_pix});
          if (e.is_pix) begin
            check("pixel_x", {25'd0, pixel_x}, e.x);
            check("pixel_y", {26'd0, pixel_y}, e.y);
            check("pixel_color", {24'd0, pixel_color}, e.val);
            check("frame_done", {31'd0, frame_done}, {31'd0, e.frame});
            n_pix++;
            if (frame_done) n_frame++;
            last_x = int'(pixel_x); last_y = int'(pixel_y); last_col = int'(pixel_color);
          end else begin
            check("cmd_byte", {24'd0, cmd_byte}, e.val);
            n_cmd++;
            last_cmd = int'(cmd_byte);
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    repeat (4) @(negedge clk);
    resn = 1'b1;
    @(negedge clk);
    check("reset_pixel_valid", {31'd0, pixel_valid}, 32'd0);
    check("reset_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("reset_frame_done", {31'd0, frame_done}, 32'd0);
    check("reset_pixel_x", {25'd0, pixel_x}, 32'd0);
    check("reset_pixel_y", {26'd0, pixel_y}, 32'd0);
    check("reset_pixel_color", {24'd0, pixel_color}, 32'd0);
    check("reset_cmd_byte", {24'd0, cmd_byte}, 32'd0);
    mon_en = 1'b1;
    oled_csn = 1'b0;
    repeat (6) @(negedge clk);

    // default window, raster order from (0,0)
    repeat (200) pix_xy();
    settle();
    check("default_count", n_pix, 200);
    check("default_last_x", last_x, 7);
    check("default_last_y", last_y, 2);
    check("default_last_color", last_col, 7 ^ 2);

    // finish the frame at (95,63) through rows 62..63
    send_byte(8'h75, 1'b0); send_byte(8'd62, 1'b0); send_byte(8'd63, 1'b0);
    send_byte(8'h15, 1'b0); send_byte(8'd0, 1'b0);  send_byte(8'd95, 1'b0);
    repeat (192) pix_xy();
    settle();
    check("frame_last_x", last_x, 95);
    check("frame_last_y", last_y, 63);
`ifdef OLED_SINK_FRAME_EN
    exp_frames = 1;
`else
    exp_frames = 0;
`endif
    check("frame_done_count", n_frame, exp_frames);
    check("window_cmds_silent", n_cmd, 0);
    send_byte(8'h75, 1'b0); send_byte(8'd0, 1'b0); send_byte(8'd63, 1'b0);

    // window commands
    base_cmd = n_cmd;
    send_byte(8'h15, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h13, 1'b0);
    send_byte(8'h75, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'h06, 1'b0);
    repeat (10) pix_xy();
    settle();
    check("window_no_cmd", n_cmd, base_cmd);
    check("window_last_x", last_x, 17);
    check("window_last_y", last_y, 5);

    // plain command
    base_pix = n_pix;
    send_byte(8'hAF, 1'b0);
    settle();
    check("plain_cmd_count", n_cmd, base_cmd + 1);
    check("plain_cmd_byte", last_cmd, 'hAF);
    check("plain_no_pixel", n_pix, base_pix);

    // aborted byte after a display reset
    resn_pulse();
    abort_bits(5);
    base_pix = n_pix;
    send_byte(8'h3C, 1'b1);
    settle();
    check("abort_count", n_pix, base_pix + 1);
    check("abort_color", last_col, 'h3C);
    check("abort_x", last_x, 0);
    check("abort_y", last_y, 0);

    // display reset mid-window
    send_byte(8'h15, 1'b0); send_byte(8'h20, 1'b0); send_byte(8'h21, 1'b0);
    resn_pulse();
    pix_xy();
    settle();
    check("resn_x", last_x, 0);
    check("resn_y", last_y, 0);
    repeat (96) pix_xy();
    settle();
    check("resn_wrap_x", last_x, 0);
    check("resn_wrap_y", last_y, 1);

    // pixel byte while waiting for a column argument
    send_byte(8'h15, 1'b0);
    send_byte(8'h55, 1'b1);
    settle();
    check("midarg_x", last_x, 1);
    check("midarg_y", last_y, 1);
    check("midarg_color", last_col, 'h55);
    send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0);
    pix_xy();
    settle();
    check("midarg_new_x", last_x, 2);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r <= 11) send_byte(8'($urandom), 1'b1);
      else if (r <= 13) send_byte(8'($urandom), 1'b0);
      else if (r == 14) begin
        send_byte(8'h15, 1'b0); send_byte(8'($urandom), 1'b0); send_byte(8'($urandom), 1'b0);
      end else if (r == 15) begin
        send_byte(8'h75, 1'b0); send_byte(8'($urandom), 1'b0); send_byte(8'($urandom), 1'b0);
      end else if (r <= 17) abort_bits($urandom_range(1, 7));
      else if (r == 18) resn_pulse();
      else begin
        oled_csn = 1'b1;
        repeat (6) @(negedge clk);
        oled_csn = 1'b0;
        repeat (6) @(negedge clk);
      end
    end
    settle();
    repeat (20) @(negedge clk);
    check("queue_empty", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
